// File: rtl/oam_dma_ctrl.sv
`default_nettype none
//-----------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : oam_dma_ctrl                                               |
// | Description : Sprite-DMA engine. A CPU write to TRIG_ADDR latches a      |
// |               source page and halts the CPU (dma_hijack). The engine     |
// |               then copies XFER_LEN bytes from {page,00} to DST_ADDR as   |
// |               alternating READ/WRITE cycles, with every READ on a "get"  |
// |               (cyc_odd=0) cycle.                                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// Ports:
//   Clk        in   CPU clock
//   Res_n      in   asynchronous active-low reset
//   bus_addr   in   CPU address (trigger decode)
//   bus_wr_n   in   CPU R/W_n, 0 = write
//   bus_din    in   CPU write data (source page on trigger)
//   rd_data    in   memory read data, valid by the edge ending a READ cycle
//   dma_hijack out  CPU halt / bus-mux select
//   dma_addr   out  DMA-driven bus address
//   dma_wr     out  DMA write strobe
//   dma_wdata  out  DMA write data (byte captured in the preceding READ)
//   busy       out  engine not idle
//   done       out  one-cycle pulse after the last write
//-----------------------------------------------------------------------------
module oam_dma_ctrl #(
   parameter int                ADDR_W    = 16,
   parameter int                XFER_LEN  = 256,
   parameter logic [ADDR_W-1:0] TRIG_ADDR = 16'h4014,
   parameter logic [ADDR_W-1:0] DST_ADDR  = 16'h2004
) (
   input  logic              Clk,
   input  logic              Res_n,
   input  logic [ADDR_W-1:0] bus_addr,
   input  logic              bus_wr_n,
   input  logic [7:0]        bus_din,
   input  logic [7:0]        rd_data,
   output logic              dma_hijack,
   output logic [ADDR_W-1:0] dma_addr,
   output logic              dma_wr,
   output logic [7:0]        dma_wdata,
   output logic              busy,
   output logic              done
);

   localparam int IDX_W = (XFER_LEN > 1) ? $clog2(XFER_LEN) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(XFER_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HALT  = 3'd1,
      S_ALIGN = 3'd2,
      S_READ  = 3'd3,
      S_WRITE = 3'd4
   } state_t;

   state_t           r_state;
   logic [7:0]       r_page;
   logic [IDX_W-1:0] r_idx;
   logic             r_cyc_odd;

   logic             w_trig;

   assign w_trig = (bus_wr_n == 1'b0) && (bus_addr == TRIG_ADDR);

   // Source address for a given index. idx never exceeds 255, so the add
   // stays within the low byte and the page bits are never carried into.
   function automatic logic [ADDR_W-1:0] rd_addr(input logic [7:0]       page,
                                                  input logic [IDX_W-1:0] i);
      logic [15:0] full;
      full = {page, 8'h00} + 16'(i);
      return ADDR_W'(full);
   endfunction

   // Outputs are registered from the state being entered, so during any
   // cycle they reflect the current state.
   always_ff @(posedge Clk or negedge Res_n) begin
      if (!Res_n) begin
         r_state    <= S_IDLE;
         r_page     <= '0;
         r_idx      <= '0;
         r_cyc_odd  <= 1'b0;
         dma_hijack <= 1'b0;
         dma_addr   <= '0;
         dma_wr     <= 1'b0;
         dma_wdata  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         r_cyc_odd <= ~r_cyc_odd;
         done      <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (w_trig) begin
                  r_page     <= bus_din;
                  r_idx      <= '0;
                  r_state    <= S_HALT;
                  dma_hijack <= 1'b1;
                  busy       <= 1'b1;
                  dma_addr   <= '0;
                  dma_wr     <= 1'b0;
               end
            end

            S_HALT: begin
               // Odd HALT means the next cycle is a get cycle: read now.
               // Otherwise burn one ALIGN cycle to reach the get slot.
               if (r_cyc_odd) begin
                  r_state  <= S_READ;
                  dma_addr <= rd_addr(r_page, r_idx);
               end else begin
                  r_state  <= S_ALIGN;
               end
            end

            S_ALIGN: begin
               r_state  <= S_READ;
               dma_addr <= rd_addr(r_page, r_idx);
            end

            S_READ: begin
               dma_wdata <= rd_data;
               r_state   <= S_WRITE;
               dma_addr  <= DST_ADDR;
               dma_wr    <= 1'b1;
            end

            S_WRITE: begin
               dma_wr <= 1'b0;
               if (r_idx == LAST_IDX) begin
                  r_state    <= S_IDLE;
                  done       <= 1'b1;
                  dma_hijack <= 1'b0;
                  busy       <= 1'b0;
                  dma_addr   <= '0;
               end else begin
                  r_idx    <= r_idx + 1'b1;
                  r_state  <= S_READ;
                  dma_addr <= rd_addr(r_page, r_idx + 1'b1);
               end
            end

            default: begin
               r_state    <= S_IDLE;
               dma_hijack <= 1'b0;
               busy       <= 1'b0;
               dma_addr   <= '0;
               dma_wr     <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_ctrl.sv
`default_nettype none
//-----------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : tb_oam_dma_ctrl                                            |
// | Description : Scoreboard bench for oam_dma_ctrl. Two instances: the      |
// |               default 256-byte engine and a 4-byte engine on 16'h4016.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
//-----------------------------------------------------------------------------
module tb_oam_dma_ctrl;

   logic        Clk = 1'b0;
   logic        Res_n;
   logic [15:0] bus_addr;
   logic        bus_wr_n;
   logic [7:0]  bus_din;

   logic        hij0, wr0, busy0, done0, hij1, wr1, busy1, done1;
   logic [15:0] addr0, addr1;
   logic [7:0]  wdata0, wdata1, rd0, rd1;

   always #5 Clk = ~Clk;

   // Memory contents as a fixed function of address.
   function automatic logic [7:0] mem_f(input logic [15:0] a);
      return (a[7:0] * 8'd37) ^ a[15:8] ^ 8'hC3;
   endfunction

   assign rd0 = mem_f(addr0);
   assign rd1 = mem_f(addr1);

   oam_dma_ctrl u_dut0 (
      .Clk(Clk), .Res_n(Res_n), .bus_addr(bus_addr), .bus_wr_n(bus_wr_n),
      .bus_din(bus_din), .rd_data(rd0), .dma_hijack(hij0), .dma_addr(addr0),
      .dma_wr(wr0), .dma_wdata(wdata0), .busy(busy0), .done(done0)
   );

   oam_dma_ctrl #(.ADDR_W(16), .XFER_LEN(4), .TRIG_ADDR(16'h4016),
                  .DST_ADDR(16'h2004)) u_dut1 (
      .Clk(Clk), .Res_n(Res_n), .bus_addr(bus_addr), .bus_wr_n(bus_wr_n),
      .bus_din(bus_din), .rd_data(rd1), .dma_hijack(hij1), .dma_addr(addr1),
      .dma_wr(wr1), .dma_wdata(wdata1), .busy(busy1), .done(done1)
   );

   // Monitored instance select.
   bit          sel = 1'b0;
   logic        m_hij, m_wr, m_busy, m_done;
   logic [15:0] m_addr;
   logic [7:0]  m_wdata;
   assign m_hij   = sel ? hij1   : hij0;
   assign m_wr    = sel ? wr1    : wr0;
   assign m_busy  = sel ? busy1  : busy0;
   assign m_done  = sel ? done1  : done0;
   assign m_addr  = sel ? addr1  : addr0;
   assign m_wdata = sel ? wdata1 : wdata0;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Independent parity model: cycles since reset release.
   int tb_cyc;
   always @(posedge Clk or negedge Res_n)
      if (!Res_n) tb_cyc <= 0;
      else        tb_cyc <= tb_cyc + 1;

   // Scoreboard queues filled at trigger time.
   logic [15:0] q_rd[$];
   logic [7:0]  q_wd[$];
   int          q_len[$];

   int run_len  = 0;
   int wr_cnt   = 0;
   bit prev_hij = 1'b0;

   always @(negedge Clk) begin
      if (!Res_n) begin
         run_len  = 0;
         wr_cnt   = 0;
         prev_hij = 1'b0;
      end else begin
         check("busy_eq_hijack", m_busy, m_hij);
         if (m_hij) begin
            run_len++;
            if (m_wr) begin
               check("wr_addr", m_addr, 16'h2004);
               check("wr_q_nonempty", q_wd.size() != 0, 1);
               if (q_wd.size() != 0) check("wr_data", m_wdata, q_wd.pop_front());
               wr_cnt++;
            end else if (m_addr != 16'h0000) begin
               check("rd_parity", tb_cyc[0], 0);
               check("rd_q_nonempty", q_rd.size() != 0, 1);
               if (q_rd.size() != 0) check("rd_addr", m_addr, q_rd.pop_front());
            end
            check("done_in_run", m_done, 0);
         end else if (prev_hij) begin
            check("done_pulse", m_done, 1);
            check("len_q_nonempty", q_len.size() != 0, 1);
            if (q_len.size() != 0) check("hijack_len", run_len, q_len.pop_front());
            check("rd_left", q_rd.size(), 0);
            check("wr_left", q_wd.size(), 0);
            run_len = 0;
            wr_cnt  = 0;
         end else begin
            check("done_idle", m_done, 0);
         end
         prev_hij = m_hij;
      end
   end

   task automatic bus_idle();
      bus_addr = 16'h0000;
      bus_wr_n = 1'b1;
      bus_din  = 8'h00;
   endtask

   task automatic bus_op(input logic [15:0] a, input logic wn, input logic [7:0] d);
      @(negedge Clk); #2;
      bus_addr = a; bus_wr_n = wn; bus_din = d;
      @(negedge Clk); #2;
      bus_idle();
   endtask

   // Trigger so that HALT lands on cyc_odd == halt_odd; push expectations.
   task automatic trig(input logic [7:0] page, input bit halt_odd, input int len);
      bit want;
      logic [15:0] a;
      want = halt_odd ? 1'b0 : 1'b1;
      @(negedge Clk); #2;
      while (tb_cyc[0] != want) begin
         @(negedge Clk); #2;
      end
      q_len.push_back(1 + (halt_odd ? 0 : 1) + 2 * len);
      for (int i = 0; i < len; i++) begin
         a = {page, 8'h00} + 16'(i);
         q_rd.push_back(a);
         q_wd.push_back(mem_f(a));
      end
      bus_addr = sel ? 16'h4016 : 16'h4014;
      bus_wr_n = 1'b0;
      bus_din  = page;
      @(negedge Clk); #2;
      bus_idle();
   endtask

   task automatic wait_done();
      int n = 0;
      while (q_len.size() != 0 && n < 3000) begin
         @(negedge Clk); #2;
         n++;
      end
      check("xfer_timeout", q_len.size(), 0);
   endtask

   initial begin
      Res_n = 1'b0;
      bus_idle();
      repeat (2) @(negedge Clk);
      #2;
      check("rst_hij0",   hij0,   0);
      check("rst_busy0",  busy0,  0);
      check("rst_addr0",  addr0,  0);
      check("rst_wr0",    wr0,    0);
      check("rst_wdata0", wdata0, 0);
      check("rst_done0",  done0,  0);
      check("rst_hij1",   hij1,   0);
      check("rst_addr1",  addr1,  0);
      Res_n = 1'b1;

      // 256-byte transfers, both HALT parities.
      trig(8'h02, 1'b1, 256);
      wait_done();
      trig(8'h02, 1'b0, 256);
      wait_done();

      // Re-trigger while busy must be ignored.
      trig(8'h02, 1'b1, 256);
      begin
         int n = 0;
         while (run_len < 100 && n < 3000) begin
            @(negedge Clk); #2;
            n++;
         end
         check("reach_cycle100", run_len >= 100, 1);
      end
      bus_op(16'h4014, 1'b0, 8'h07);
      wait_done();

      // Non-trigger accesses.
      bus_op(16'h4014, 1'b1, 8'h09);
      bus_op(16'h4015, 1'b0, 8'h09);
      repeat (2) begin
         @(negedge Clk); #2;
         check("no_trig_busy", busy0, 0);
         check("no_trig_hij",  hij0,  0);
      end

      // Reset in the middle of WRITE at idx 37.
      trig(8'h02, 1'b1, 256);
      begin
         int n = 0;
         while (wr_cnt < 38 && n < 3000) begin
            @(negedge Clk); #2;
            n++;
         end
         check("reach_idx37", wr_cnt, 38);
      end
      check("pre_rst_wr", wr0, 1);
      Res_n = 1'b0;
      #1;
      check("mid_rst_hij",   hij0,   0);
      check("mid_rst_busy",  busy0,  0);
      check("mid_rst_addr",  addr0,  0);
      check("mid_rst_wr",    wr0,    0);
      check("mid_rst_wdata", wdata0, 0);
      check("mid_rst_done",  done0,  0);
      q_rd.delete();
      q_wd.delete();
      q_len.delete();
      repeat (2) @(negedge Clk);
      #2;
      Res_n = 1'b1;
      trig(8'h02, 1'b0, 256);
      wait_done();

      // 4-byte instance.
      sel = 1'b1;
      trig(8'h03, 1'b1, 4);
      wait_done();
      trig(8'h03, 1'b0, 4);
      wait_done();
      repeat (3) @(negedge Clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
